// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss - MM:SS stopwatch (00:00 .. 59:59) with start/pause/clear control.
//
// A programmable prescaler produces one tick every TICK_DIV clocks while running.
// Four cascaded BCD counters advance on each tick. Pushbuttons are synchronised
// and edge-detected into one-cycle pulses. Four decoders drive active-low
// 7-segment patterns {g,f,e,d,c,b,a}.
//
// Optional feature: define STOPWATCH_LAP_EN to enable the lap-hold display freeze.
// Without it, lap is ignored and hold is tied low.
//
// Ports:
//   clk_50      system clock, rising edge
//   rst         asynchronous reset, active-low
//   start_stop  pushbutton level; a rising edge toggles run/pause or starts from idle
//   clear       pushbutton level; a rising edge zeroes the count in IDLE/PAUSE
//   lap         pushbutton level; a rising edge freezes/releases the display
//   running     high while in RUN (registered)
//   hold        high while the display is frozen (registered)
//   wrapped     sticky rollover flag from 59:59 to 00:00 (registered)
//   OUT_M10/OUT_M1/OUT_S10/OUT_S1  7-segment patterns, active-low
module stopwatch_mmss #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic       hold,
  output logic       wrapped,
  output logic [6:0] OUT_M10,
  output logic [6:0] OUT_M1,
  output logic [6:0] OUT_S10,
  output logic [6:0] OUT_S1
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] btn;
  assign btn = {lap, clear, start_stop};
`else
  localparam int NB = 2;
  logic [NB-1:0] btn;
  logic          unused_lap;
  assign btn        = {clear, start_stop};
  assign unused_lap = lap;
`endif

  logic [NB-1:0] btn_p0, btn_p1, btn_p2, btn_pulse;
  logic          ss_evt, clr_evt;
  state_t        state_q, state_d;
  logic          clr_act;
  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    dig_s1, dig_s10, dig_m1, dig_m10;
  logic [3:0]    disp_s1, disp_s10, disp_m1, disp_m10;
  logic          s1_top, s10_top, m1_top, m10_top;

  // Stage p0/p1: two-flop synchroniser; p2 and pulse: registered rising-edge detect
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      btn_p0    <= '0;
      btn_p1    <= '0;
      btn_p2    <= '0;
      btn_pulse <= '0;
    end else begin
      btn_p0    <= btn;
      btn_p1    <= btn_p0;
      btn_p2    <= btn_p1;
      btn_pulse <= btn_p1 & ~btn_p2;
    end
  end

  assign ss_evt  = btn_pulse[0];
  assign clr_evt = btn_pulse[1];

  // Control: state register
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
    end
  end

  // In RUN, start_stop always wins and clear is dropped; elsewhere clear wins.
  always_comb begin
    state_d = state_q;
    clr_act = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_evt)     clr_act = 1'b1;
        else if (ss_evt) state_d = RUN;
      end
      RUN: begin
        if (ss_evt) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_evt) begin
          clr_act = 1'b1;
          state_d = IDLE;
        end else if (ss_evt) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prescaler stage: holds its value outside RUN so a resumed second keeps its fraction
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clr_act) begin
        presc <= '0;
      end else if (state_q == RUN) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign s1_top  = (dig_s1  == 4'd9);
  assign s10_top = (dig_s10 == 4'd5);
  assign m1_top  = (dig_m1  == 4'd9);
  assign m10_top = (dig_m10 == 4'd5);

  // Digit stage: BCD cascade advanced by the registered tick
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      dig_s1  <= '0;
      dig_s10 <= '0;
      dig_m1  <= '0;
      dig_m10 <= '0;
      wrapped <= 1'b0;
    end else if (clr_act) begin
      dig_s1  <= '0;
      dig_s10 <= '0;
      dig_m1  <= '0;
      dig_m10 <= '0;
      wrapped <= 1'b0;
    end else if (tick) begin
      dig_s1 <= s1_top ? 4'd0 : dig_s1 + 4'd1;
      if (s1_top) begin
        dig_s10 <= s10_top ? 4'd0 : dig_s10 + 4'd1;
        if (s10_top) begin
          dig_m1 <= m1_top ? 4'd0 : dig_m1 + 4'd1;
          if (m1_top) begin
            dig_m10 <= m10_top ? 4'd0 : dig_m10 + 4'd1;
            if (m10_top) wrapped <= 1'b1;
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       lap_evt;
  logic [3:0] lap_s1, lap_s10, lap_m1, lap_m10;

  assign lap_evt = btn_pulse[2];

  // Lap stage: first lap in RUN snapshots the live count; the next lap releases it
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      hold    <= 1'b0;
      lap_s1  <= '0;
      lap_s10 <= '0;
      lap_m1  <= '0;
      lap_m10 <= '0;
    end else if (clr_act) begin
      hold <= 1'b0;
    end else if (lap_evt) begin
      if (!hold && (state_q == RUN)) begin
        hold    <= 1'b1;
        lap_s1  <= dig_s1;
        lap_s10 <= dig_s10;
        lap_m1  <= dig_m1;
        lap_m10 <= dig_m10;
      end else if (hold && (state_q != IDLE)) begin
        hold <= 1'b0;
      end
    end
  end

  assign disp_s1  = hold ? lap_s1  : dig_s1;
  assign disp_s10 = hold ? lap_s10 : dig_s10;
  assign disp_m1  = hold ? lap_m1  : dig_m1;
  assign disp_m10 = hold ? lap_m10 : dig_m10;
`else
  assign hold     = 1'b0;
  assign disp_s1  = dig_s1;
  assign disp_s10 = dig_s10;
  assign disp_m1  = dig_m1;
  assign disp_m10 = dig_m10;
`endif

  assign OUT_S1  = seg7(disp_s1);
  assign OUT_S10 = seg7(disp_s10);
  assign OUT_M1  = seg7(disp_m1);
  assign OUT_M10 = seg7(disp_m10);

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Testbench for stopwatch_mmss (TICK_DIV=4). Randomised button levels are compared
// every cycle against a reference model that keeps elapsed time as a plain second
// count (0..3599) and derives display digits by division.
module tb_stopwatch_mmss;

  localparam int TD      = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic       start_stop, clear, lap;
  logic       running, hold, wrapped;
  logic [6:0] OUT_M10, OUT_M1, OUT_S10, OUT_S1;

  stopwatch_mmss #(.TICK_DIV(TD)) dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .running    (running),
    .hold       (hold),
    .wrapped    (wrapped),
    .OUT_M10    (OUT_M10),
    .OUT_M1     (OUT_M1),
    .OUT_S10    (OUT_S10),
    .OUT_S1     (OUT_S1)
  );

  always #5 clk_50 = ~clk_50;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int       m_st, m_secs, m_presc, m_lap_secs;
  bit       m_tick, m_wrapped, m_hold;
  bit [4:0] h_ss, h_cl;
`ifdef STOPWATCH_LAP_EN
  bit [4:0] h_lp;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       seg_of = 7'b1000000;
      1:       seg_of = 7'b1111001;
      2:       seg_of = 7'b0100100;
      3:       seg_of = 7'b0110000;
      4:       seg_of = 7'b0011001;
      5:       seg_of = 7'b0010010;
      6:       seg_of = 7'b0000010;
      7:       seg_of = 7'b1111000;
      8:       seg_of = 7'b0000000;
      9:       seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] exp_segs();
    int v;
    v = m_hold ? m_lap_secs : m_secs;
    exp_segs = {seg_of(v / 600), seg_of((v / 60) % 10), seg_of((v % 60) / 10), seg_of(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_secs = 0; m_presc = 0; m_lap_secs = 0;
    m_tick = 0; m_wrapped = 0; m_hold = 0;
    h_ss = '0; h_cl = '0;
`ifdef STOPWATCH_LAP_EN
    h_lp = '0;
`endif
  endtask

  // A level sampled at edge k acts on the state at edge k+3 if it was a rise.
  task automatic model_edge();
    bit e_ss, e_cl, clr;
    int st_n;
    h_ss = {h_ss[3:0], start_stop};
    h_cl = {h_cl[3:0], clear};
    e_ss = h_ss[3] & ~h_ss[4];
    e_cl = h_cl[3] & ~h_cl[4];
    clr  = 1'b0;
    st_n = m_st;
    if (m_st == S_RUN) begin
      if (e_ss) st_n = S_PAUSE;
    end else if (e_cl) begin
      clr  = 1'b1;
      st_n = S_IDLE;
    end else if (e_ss) begin
      st_n = S_RUN;
    end
    if (clr) begin
      m_secs = 0; m_presc = 0; m_tick = 0; m_wrapped = 0; m_hold = 0;
    end else begin
`ifdef STOPWATCH_LAP_EN
      h_lp = {h_lp[3:0], lap};
      if (h_lp[3] & ~h_lp[4]) begin
        if (!m_hold && m_st == S_RUN) begin
          m_hold = 1; m_lap_secs = m_secs;
        end else if (m_hold && m_st != S_IDLE) begin
          m_hold = 0;
        end
      end
`endif
      if (m_tick) begin
        if (m_secs == 3599) m_wrapped = 1;
        m_secs = (m_secs + 1) % 3600;
      end
      if (m_st == S_RUN) begin
        m_tick  = (m_presc == TD - 1);
        m_presc = (m_presc + 1) % TD;
      end else begin
        m_tick = 0;
      end
    end
`ifdef STOPWATCH_LAP_EN
    if (clr) h_lp = {h_lp[3:0], lap};
`endif
    m_st = st_n;
  endtask

  task automatic compare();
    check("running", running, (m_st == S_RUN));
    check("hold", hold, m_hold);
    check("wrapped", wrapped, m_wrapped);
    check("segments", {OUT_M10, OUT_M1, OUT_S10, OUT_S1}, exp_segs());
  endtask

  // Drive levels just after an edge, advance one clock, then compare 1 ns after it.
  task automatic step(input bit ss, input bit cl, input bit lp);
    start_stop = ss; clear = cl; lap = lp;
    @(posedge clk_50);
    if (rst) model_edge();
    else     model_reset();
    #1;
    compare();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press(input bit ss, input bit cl, input bit lp);
    step(ss, cl, lp);
    step(ss, cl, lp);
    idle_cycles(4);
  endtask

  initial begin
    bit rs, rc, rl;
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    #1;
    compare();
    idle_cycles(3);
    rst = 1'b1;

    // Start and count through 10 seconds
    step(1, 0, 0);
    idle_cycles(45);
    check("digits_at_10s", {OUT_S10, OUT_S1}, {seg_of(1), seg_of(0)});

    // Clear alone in RUN is ignored; clear+start_stop in RUN pauses
    press(0, 1, 0);
    idle_cycles(5);
    press(1, 1, 0);
    idle_cycles(100);
    press(1, 0, 0);
    idle_cycles(13);
    press(0, 0, 1);
    idle_cycles(14);
    press(0, 0, 1);
    press(1, 0, 0);
    press(0, 1, 0);
    check("idle_after_clear", running, 1'b0);

    // Wrap from 59:59 to 00:00
    press(1, 0, 0);
    idle_cycles(3600 * TD + 20);
    check("wrap_flag", wrapped, 1'b1);
    press(1, 0, 0);
    idle_cycles(30);
    press(0, 1, 0);

    // Randomised button activity
    rs = 0; rc = 0; rl = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 11) == 0) rs = ~rs;
      if ($urandom_range(0, 39) == 0) rc = ~rc;
      if ($urandom_range(0, 15) == 0) rl = ~rl;
      step(rs, rc, rl);
    end
    idle_cycles(6);
    press(0, 1, 0);
    press(0, 1, 0);

    // Asynchronous reset in mid-run
    press(1, 0, 0);
    idle_cycles(22);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare();
    check("reset_running", running, 1'b0);
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_mmss.md
# stopwatch_mmss

Parametrised MM:SS stopwatch for the board-level timer path, driven from the 50 MHz board clock. A programmable prescaler feeds four cascaded BCD digit counters (00:00 to 59:59) under a start/pause/clear state machine. It adds synchronised, edge-detected pushbutton inputs and an optional lap-hold display freeze. Four on-chip decoders produce the active-low 7-segment patterns.

## Interface

- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick; legal range is ≥2.
- `clk_50` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start_stop` input, 1 bit: asynchronous pushbutton level, active-high; acts on its rising edge.
- `clear` input, 1 bit: asynchronous pushbutton level, active-high; acts on its rising edge.
- `lap` input, 1 bit: asynchronous pushbutton level, active-high; acts on its rising edge.
- `running` output, 1 bit: high while the FSM is in RUN.
- `hold` output, 1 bit: high while the lap display freeze is active.
- `wrapped` output, 1 bit: sticky flag, set when the count rolls over from 59:59 to 00:00.
- `OUT_M10`, `OUT_M1`, `OUT_S10`, `OUT_S1` outputs, 7 bits each: segment patterns `{g,f,e,d,c,b,a}`, active-low.

## Operation

- **Input path.** Each button passes through a 2-FF synchronizer and then a rising-edge detector, producing a one-cycle internal pulse.
- **FSM states.**
  - IDLE → RUN on start_stop.
  - RUN → PAUSE on start_stop.
  - PAUSE → RUN on start_stop.
  - PAUSE → IDLE on clear.
  - clear in IDLE: state stays IDLE, and the clear action below is still applied.
  - clear in RUN: ignored.
- **Clear action (IDLE and PAUSE only).** Zeroes all digits and the prescaler, and clears `wrapped` and `hold`.
- **Prescaler.** Counts 0..TICK_DIV-1 only in RUN. It holds its value in PAUSE, so a resumed second keeps its elapsed fraction. When it reaches TICK_DIV-1 it emits a 1-cycle tick and returns to 0.
- **Digit counters (on tick).**
  - S1 counts 0-9. On carry, S10 counts 0-5.
  - On carry, M1 counts 0-9. On carry, M10 counts 0-5.
  - 59:59 + tick → 00:00 and `wrapped` is set to 1. `wrapped` stays set until clear or reset.
- **Decoder.** Combinational, one per digit.
  - Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other code displays 1111111 (blank).
- **Simultaneous events.**
  - start_stop and clear in the same cycle: in RUN, start_stop wins (→ PAUSE; clear is dropped). In PAUSE or IDLE, clear wins.
  - lap together with start_stop: both actions are applied.

## Timing

- **Reset values.** State is IDLE; all digits are 0; prescaler is 0. `running`=0, `hold`=0, `wrapped`=0. All four `OUT_*` show 1000000.
- **Button latency.** A button level rising before clock edge N produces its internal pulse at edge N+2. The state and flags update at edge N+3.
- **Tick latency.** The tick fires TICK_DIV cycles after RUN is entered from a zeroed prescaler. Digits update on the edge following the tick.
- **Output timing.** `running`, `hold` and `wrapped` are registered. The segment outputs are combinational from the display registers.
- **Async reset.** Reset asserts regardless of the clock and aborts any state: mid-count, held or wrapped. After deassertion the block restarts from the reset values.

## Configuration

- Macro `STOPWATCH_LAP_EN`.
- **Defined:**
  - A lap pulse in RUN with `hold`=0 copies the live digits into the display registers and sets `hold`.
  - The next lap pulse (in RUN or PAUSE) clears `hold`, and the display tracks the live digits again.
  - While `hold`=1, the live count keeps advancing.
- **Undefined:**
  - The `lap` input is ignored.
  - `hold` is tied to 0.
  - The display always shows the live digits.

## Test plan

All scenarios use TICK_DIV=4.

- **Reset.** Assert reset mid-run at 00:07 → within the same cycle `running`=0 and `wrapped`=0, all OUT_*=1000000. After release the block stays at 00:00.
- **Start and count.** Pulse start_stop and run 40 cycles → `running`=1 at edge 3, OUT_S1=0010010 (5) after ~5 ticks; total ticks = 10 gives OUT_S10=1111001, OUT_S1=1000000.
- **Pause and clear.** Pause at 00:03 with the prescaler at 2 → the digits hold for 100 cycles. Resume → the next tick comes 2 cycles after RUN re-entry. Pause again, then clear → 00:00 and IDLE.
- **Clear ignored in RUN.** Clear during RUN has no effect. clear+start_stop together in RUN → PAUSE with the count kept.
- **Wrap.** Preload to 59:58 by running 3598 ticks, then run 2 more ticks → 00:00 and `wrapped`=1. `wrapped` persists until clear.
- **Lap hold (STOPWATCH_LAP_EN).** Lap at 00:04 → display frozen at 00:04 and `hold`=1. After 3 more ticks, lap again → display shows 00:07 and `hold`=0. With the macro undefined, lap has no effect.
